dl_skid_buf: RTL and testbench
==============================

Name: dl_skid_buf

Overview:
- Parameterized elastic pipeline stage with a two-entry valid/ready skid buffer, one main register and one skid register.
- Sits directly downstream of a datapath 2-to-1 mux (for example the next-PC or operand-select mux). It registers the mux output and decouples upstream/downstream backpressure at full throughput.
- in_rdy is driven from a register, so no combinational path runs from out_rdy to in_rdy.

Parameters:
NUM_BITS, 1, width of the data word carried through the stage

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of all buffered entries
in_val  input  1  upstream word valid
in_rdy  output  1  stage can accept a word this cycle (registered)
in_data  input  NUM_BITS  upstream word (mux output)
out_val  output  1  out_data holds a valid word
out_rdy  input  1  downstream accepts out_data this cycle
out_data  output  NUM_BITS  oldest buffered word

Behaviour:
- Handshake
  - Input transfer (push) occurs when in_val & in_rdy at a rising edge.
  - Output transfer (pop) occurs when out_val & out_rdy at a rising edge.
  - in_val may assert while in_rdy=0; no transfer happens and in_data is ignored.
- Registered outputs
  - out_val, out_data and in_rdy are all registered. No combinational paths exist.
- State (entries held)
  - EMPTY: 0 entries; out_val=0, in_rdy=1.
  - ONE: 1 entry in main; out_val=1, in_rdy=1.
  - FULL: main + skid both valid; out_val=1, in_rdy=0.
- Transitions (flush=0)
  - EMPTY + push -> ONE; main <= in_data.
  - ONE + push + pop -> ONE; main <= in_data.
  - ONE + push, no pop -> FULL; skid <= in_data, main unchanged.
  - ONE + pop, no push -> EMPTY.
  - FULL + pop -> ONE; main <= skid. No push is possible, since in_rdy=0.
  - FULL, no pop -> FULL, holding both entries.
  - Any state, no push and no pop -> hold.
- Ordering: strict FIFO order. The skid word is always younger than the main word.
- Latency and throughput
  - Latency is 1 cycle: a word pushed at edge N is on out_data with out_val=1 after edge N, provided the stage was EMPTY or popping at edge N.
  - Sustained throughput is 1 word/cycle while out_rdy=1.
- Stability: while out_val=1 and out_rdy=0, out_data and out_val hold stable (AXI-style; no retraction).
- Reset (rst=1 at edge)
  - Returns the stage to EMPTY: out_val=0, in_rdy=1, out_data=0, skid data=0.
  - Takes priority over flush, push and pop.
  - Reset mid-operation discards all held words.
- Flush (flush=1 at edge, rst=0)
  - Returns the stage to EMPTY: out_val=0, in_rdy=1.
  - Any push or pop in that cycle is discarded.
  - Data registers are not required to clear.
- Width: data is passed unmodified. NUM_BITS=1 must be supported.
- X handling: in_data is not sampled unless push. After reset, out_data never shows X while out_val=0.

Test Plan:
- Reset: hold rst=1 two cycles with in_val=1, in_data=0xA5 (NUM_BITS=8) -> out_val=0, in_rdy=1, out_data=0x00. After release, in_val=1 -> out_val=1, out_data=0xA5 next cycle.
- Streaming: out_rdy=1, push 0x01..0x10 on consecutive cycles -> out_data=0x01..0x10 on consecutive cycles, 1-cycle latency, in_rdy=1 throughout, no bubbles.
- Backpressure/skid
  - Stimulus: push 0x11, then 0x22, with out_rdy=0.
  - in_rdy drops to 0 after the second push; out_data holds 0x11.
  - Raise out_rdy: pops 0x11 then 0x22 on consecutive cycles; in_rdy returns to 1 the cycle after the first pop.
- Random stall
  - Stimulus: 1000 random words; in_val and out_rdy each toggled randomly at 50%.
  - Scoreboard shows all words delivered, in order, none duplicated.
  - out_data is stable whenever out_val=1 and out_rdy=0.
- Flush in FULL: fill with 0x33, 0x44, then assert flush with in_val=1, in_data=0x55 -> out_val=0 and in_rdy=1 next cycle. 0x55 is not accepted, and 0x33/0x44 never appear.
- Simultaneous push+pop in ONE: main=0x66, push 0x77 with out_rdy=1 -> next cycle out_data=0x77, out_val=1, in_rdy=1, state stays ONE.

Source files
------------

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer that registers a datapath mux output.
// in_rdy and out_val are direct state-register bits, so no combinational path crosses the stage.
module dl_skid_buf #(
  parameter int NUM_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [NUM_BITS-1:0] out_data
);

  // Encoding chosen so bit 1 is in_rdy and bit 0 is out_val.
  typedef enum logic [1:0] {
    EMPTY = 2'b10,
    ONE   = 2'b11,
    FULL  = 2'b01
  } state_t;

  state_t state, state_next;
  logic [NUM_BITS-1:0] main_data, skid_data;
  logic push, pop;

  assign push = in_val & state[1];
  assign pop  = out_rdy & state[0];

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_next = ONE;
        ONE: begin
          if (push && !pop)      state_next = FULL;
          else if (pop && !push) state_next = EMPTY;
        end
        FULL:    if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_rdy   = state[1];
    out_val  = state[0];
    out_data = main_data;
  end

  // Main always holds the oldest word; skid only fills when main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (push) main_data <= in_data;
        ONE: begin
          if (push && pop) main_data <= in_data;
          else if (push)   skid_data <= in_data;
        end
        FULL:  if (pop) main_data <= skid_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_skid_buf.sv
// Scoreboard bench for dl_skid_buf: a word queue models occupancy, ordering and output data.
module tb_dl_skid_buf;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, flush, in_val, in_rdy, out_val, out_rdy;
  logic [W-1:0] in_data, out_data;

  int           tests = 0;
  int           failures = 0;
  logic [W-1:0] q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;

  always #5 clk = ~clk;

  dl_skid_buf #(.NUM_BITS(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks outputs against the queue, then advances the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                      input logic f, input logic rs);
    bit do_pop, do_push;
    in_val = v; in_data = d; out_rdy = r; flush = f; rst = rs;
    check("in_rdy", in_rdy, q.size() < 2);
    check("out_val", out_val, q.size() > 0);
    if (q.size() > 0) check("out_data", out_data, q[0]);
    if (stall_prev) check("stable", out_data, data_prev);
    stall_prev = out_val && !r && !f && !rs;
    data_prev  = out_data;
    do_pop  = (q.size() > 0) && r;
    do_push = v && (q.size() < 2);
    if (rs || f) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int cycles;
    bit v;
    logic [W-1:0] d;

    rst = 1'b1; flush = 1'b0; in_val = 1'b0; in_data = '0; out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles with a word offered
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    check("reset_out_data", out_data, 32'h00);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Backpressure into the skid register
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush while FULL, with a push offered
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Simultaneous push and pop while holding one word
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation discards held words
    step(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h89, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h8A, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random stalls on both sides
    sent = 0;
    cycles = 0;
    while ((sent < 1000 || q.size() > 0) && cycles < 20000) begin
      v = (sent < 1000) && ($urandom_range(0, 1) == 1);
      d = W'($urandom);
      if (v && q.size() < 2) sent++;
      step(v, d, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      cycles++;
    end
    check("drain_timeout", q.size(), 0);
    check("random_sent", sent, 1000);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
